// File: rtl/dcache_wb_if.sv
// Processor-side and memory-side buses of the write-back D-cache.
// The cache uses the slave modport; the core and memory side use master.
interface dcache_wb_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_wb #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_wb_if.slave  bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IW = $clog2(NUM_BLOCKS);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e                 state_q;
    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [NUM_BLOCKS-1:0]  dirty_q;
    logic [TW-1:0]          tag_q  [NUM_BLOCKS];
    logic [3:0][31:0]       data_q [NUM_BLOCKS];
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [27:0]            mem_addr_q;
    logic [127:0]           mem_wdata_q;

    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [1:0]    req_word;
    logic          req_active;
    logic          req_hit;

    assign req_idx    = bus.proc_addr[IW+1:2];
    assign req_tag    = bus.proc_addr[29:IW+2];
    assign req_word   = bus.proc_addr[1:0];
    assign req_active = bus.proc_read | bus.proc_write;
    assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // A request only completes from IDLE; the replay after refill is what lets it hit.
    assign bus.proc_stall = req_active && !((state_q == IDLE) && req_hit);
    assign bus.proc_rdata = data_q[req_idx][req_word];

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            // NOTE: the tag and data arrays are plain flops, so they are cleared
            // here as well; an SRAM-based array could not be reset this way.
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_active) begin
                        if (req_hit) begin
                            if (bus.proc_write) begin
                                data_q[req_idx][req_word] <= bus.proc_wdata;
                                dirty_q[req_idx]          <= 1'b1;
                            end
                        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[req_idx], req_idx};
                            mem_wdata_q <= data_q[req_idx];
                            state_q     <= WRITEBACK;
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= bus.proc_addr[29:2];
                            state_q    <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= bus.proc_addr[29:2];
                        state_q     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        data_q[req_idx]  <= bus.mem_rdata;
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        tag_q[req_idx]   <= req_tag;
                        mem_read_q       <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        replay_q;

    // The cycle right after a refill is the replay of a missed access; it is
    // not counted as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            replay_q <= (state_q == ALLOCATE) && bus.mem_ready;
            if ((state_q == IDLE) && req_active) begin
                if (req_hit) begin
                    if (!replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
                end else begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
